alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, for example the execute stage and a branch/address unit. It accepts one operation at a time over a valid/ready handshake and registers the operands. It drives the ALU for exactly one cycle, captures the result and flags, and returns them on a shared response channel with backpressure.

## Interface
Parameters:
- WIDTH, 32, operand and result width; ALU control is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester N presents an operation.
- req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
- req0_op / req1_op  input  4  ALU control code.
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
- alu_in1, alu_in2  output  WIDTH  to ALU input1/input2.
- alu_ctr  output  4  to ALU aluCtr.
- alu_res  input  WIDTH  from ALU aluRes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_result  output  WIDTH  captured result.
- rsp_zero  output  1  1 when rsp_result == 0.
- rsp_err  output  1  unsupported op code.

## Operation
- Supported ops:
  - 0010 add
  - 0110 sub
  - 0000 and
  - 0001 or
  - 0111 unsigned set-less-than
  - 1100 not input1
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to one valid requester. If both are valid, the grant goes to the one not granted last (round-robin).
  - last_grant resets to 1, so req0 wins the first contested cycle.
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N. Ready depends combinationally on valid; at most one ready is high per cycle.
  - On handshake: latch op, a, b and id into registers; update last_grant; go to EXEC.
- EXEC (exactly 1 cycle):
  - Drive alu_in1/alu_in2/alu_ctr from the latched registers.
  - At the clock edge, capture alu_res into rsp_result. rsp_zero is computed by this block from the captured value; the ALU zero output is not used.
  - Unsupported op: do not sample alu_res. rsp_result = 0, rsp_zero = 1, rsp_err = 1.
  - Go to RESP.
- RESP:
  - rsp_valid = 1 with all rsp_* fields stable until rsp_valid & rsp_ready; then go to IDLE.
  - No new request is accepted while in EXEC or RESP.
- ALU drive outside EXEC: alu_ctr = 4'b0010, alu_in1 = alu_in2 = 0. This gives a defined, glitch-free idle ALU output.
- Arithmetic:
  - WIDTH-bit modulo for add and sub; carry/borrow is discarded.
  - slt is unsigned and yields 0 or 1, zero-extended.

## Timing
- Reset values:
  - FSM state: IDLE.
  - last_grant: 1.
  - req0_ready, req1_ready: 0.
  - rsp_valid, rsp_id, rsp_result, rsp_err: 0.
  - rsp_zero: 1 (follows result == 0).
  - alu_ctr: 0010.
  - alu_in1, alu_in2: 0.
- Latency: handshake in cycle T; ALU is driven in T+1; rsp_valid rises in T+2.
- Minimum turnaround, with rsp_ready held at 1:
  - Response is accepted in T+2.
  - IDLE in T+3; the next handshake happens in T+3.
  - Throughput is 1 operation per 3 cycles.
- rsp_ready low: the block stays in RESP indefinitely. Requesters see ready = 0 throughout.
- Requesters must hold valid/op/a/b stable until ready. Dropping valid before ready is legal; nothing is latched.
- Simultaneous valid on both ports every cycle: grants strictly alternate 0, 1, 0, 1…
- Reset asserted mid-EXEC or mid-RESP: the transaction is dropped with no response. All outputs return to reset values immediately (asynchronous).

## Test plan
- Single add: req0 op=0010, a=5, b=7 in cycle 1 -> req0_ready=1 in cycle 1; alu_ctr=0010, alu_in1=5 in cycle 2; rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0 in cycle 3.
- Contention: both valid continuously, rsp_ready=1 -> grants alternate, 0 first. Checks:
  - rsp_id sequence 0, 1, 0, 1.
  - One response every 3 cycles.
  - Neither requester wins twice in a row.
- Sub to zero and wrap: sub a=9, b=9 -> result 0, zero=1. Add a=FFFFFFFF, b=1 -> result 0, zero=1. Slt a=1, b=FFFFFFFF -> result 1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> response fields stay constant, both readys stay 0, response is accepted on the cycle rsp_ready=1, IDLE on the next cycle.
- Unsupported op 1111, a=3, b=4 -> rsp_err=1, rsp_result=0, rsp_zero=1; alu_ctr stays 0010 and alu_in1/alu_in2 stay 0 during EXEC.
- Reset in EXEC -> rsp_valid never asserts and outputs return to reset values. After release, the first contested request is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational ALU between two requesters.
// Each accepted operation drives the ALU for one cycle, then holds a response until it is consumed.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic last_grant, grant, hs, ok, drive;
  logic [3:0] op;
  logic [WIDTH-1:0] a, b;
  assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state == IDLE) & req1_valid & grant;
  assign hs = req0_ready | req1_ready;
  assign ok = op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
  // unsupported ops leave the ALU at its idle drive
  assign drive = (state == EXEC) & ok;
  assign alu_ctr = drive ? op : 4'b0010;
  assign alu_in1 = drive ? a : '0;
  assign alu_in2 = drive ? b : '0;
  assign rsp_valid = state == RESP;
  assign rsp_zero = rsp_result == '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = hs ? EXEC : IDLE;
      EXEC: state_n = RESP;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      op <= '0;
      a <= '0;
      b <= '0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) begin
        op <= grant ? req1_op : req0_op;
        a <= grant ? req1_a : req0_a;
        b <= grant ? req1_b : req0_b;
        rsp_id <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_result <= ok ? alu_res : '0;
        rsp_err <= ~ok;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus handwritten contention, backpressure and reset sequences.
module tb_alu_arbiter;
  logic clk = 0, reset = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_op = 0, req1_op = 0, alu_ctr;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [31:0] alu_in1, alu_in2, alu_res, rsp_result;
  logic rsp_valid, rsp_ready = 1, rsp_id, rsp_zero, rsp_err;
  int n_chk = 0, n_fail = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctr(alu_ctr), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // external ALU
  always_comb begin
    alu_res = '0;
    case (alu_ctr)
      4'b0010: alu_res = alu_in1 + alu_in2;
      4'b0110: alu_res = alu_in1 - alu_in2;
      4'b0000: alu_res = alu_in1 & alu_in2;
      4'b0001: alu_res = alu_in1 | alu_in2;
      4'b0111: alu_res = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~alu_in1;
      default: alu_res = '0;
    endcase
  end

  typedef struct {
    logic id;
    logic [3:0] op;
    logic [31:0] a, b, res;
    logic zero, err;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input vec_t v);
    if (v.id) begin
      req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    #1;
    chk("ready_granted", v.id ? req1_ready : req0_ready, 1);
    chk("ready_other", v.id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("exec_alu_ctr", alu_ctr, v.err ? 4'b0010 : v.op);
    chk("exec_alu_in1", alu_in1, v.err ? 32'd0 : v.a);
    chk("exec_alu_in2", alu_in2, v.err ? 32'd0 : v.b);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", rsp_zero, v.zero);
    chk("rsp_err", rsp_err, v.err);
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    vecs[0] = '{0, 4'b0010, 32'd5,        32'd7,        32'd12,       0, 0};
    vecs[1] = '{1, 4'b0110, 32'd9,        32'd9,        32'd0,        1, 0};
    vecs[2] = '{0, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0};
    vecs[3] = '{1, 4'b0111, 32'd1,        32'hFFFFFFFF, 32'd1,        0, 0};
    vecs[4] = '{0, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 0};
    vecs[5] = '{1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0};
    vecs[6] = '{0, 4'b0001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0, 0};
    vecs[7] = '{1, 4'b1100, 32'd0,        32'd8,        32'hFFFFFFFF, 0, 0};
    vecs[8] = '{0, 4'b1111, 32'd3,        32'd4,        32'd0,        1, 1};
    vecs[9] = '{1, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0};

    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 1);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_ctr", alu_ctr, 4'b0010);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    do_reset();

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // contention: grants alternate from req0, one response every 3 cycles
    do_reset();
    req0_valid = 1; req0_op = 4'b0010; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1; req1_op = 4'b0110; req1_a = 32'd10; req1_b = 32'd4;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("cont_ready0", req0_ready, c % 6 == 0);
      chk("cont_ready1", req1_ready, c % 6 == 3);
      chk("cont_rsp_valid", rsp_valid, c % 3 == 2);
      if (c % 3 == 2) begin
        chk("cont_rsp_id", rsp_id, c % 6 == 5);
        chk("cont_rsp_result", rsp_result, (c % 6 == 5) ? 32'd6 : 32'd3);
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 0; req1_valid = 0;

    // backpressure: response held while rsp_ready is low
    rsp_ready = 0;
    req1_valid = 1; req1_op = 4'b0001; req1_a = 32'h11; req1_b = 32'h22;
    #1 chk("bp_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1;
    chk("bp_exec_ready0", req0_ready, 0);
    chk("bp_exec_ready1", req1_ready, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 32'h33);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    #1 chk("bp_accept_valid", rsp_valid, 1);
    @(posedge clk); #1;
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_ready0", req0_ready, 1);
    chk("bp_idle_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // reset during EXEC drops the transaction and restores round-robin start
    req0_valid = 1; req0_op = 4'b0010; req0_a = 32'hAA; req0_b = 32'h55;
    #1 chk("re_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    chk("re_exec_in1", alu_in1, 32'hAA);
    #2 reset = 1;
    #1;
    chk("re_alu_ctr", alu_ctr, 4'b0010);
    chk("re_alu_in1", alu_in1, 0);
    chk("re_alu_in2", alu_in2, 0);
    chk("re_rsp_valid", rsp_valid, 0);
    chk("re_rsp_result", rsp_result, 0);
    chk("re_rsp_zero", rsp_zero, 1);
    chk("re_rsp_err", rsp_err, 0);
    @(negedge clk) reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("re_no_rsp", rsp_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("re_first_ready0", req0_ready, 1);
    chk("re_first_ready1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
